// File: rtl/cordic_sig_checker.sv
// ============================================================================
// Module   : cordic_sig_checker
// Purpose  : BIST sequencer and signature checker for the CORDIC test
//            wrapper. It seeds the wrapper, waits for the signature and
//            compares it with a golden value.
// Options  : define CORDIC_SIG_CHECKER_FAIL_CNT_EN to build the failed-run
//            counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sig_checker #(
    parameter int DATA_WIDTH    = 56,
    parameter int SIG_WIDTH     = 54,
    parameter int STOP_WIDTH    = 49,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_async_rst_n,
    input  logic                     i_start,
    input  logic [DATA_WIDTH-1:0]    i_seed,
    input  logic [STOP_WIDTH-1:0]    i_stop_code,
    input  logic [SIG_WIDTH-1:0]     i_golden,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    output logic [1:0]               o_mode,
    output logic [2:0]               o_bypass,
    output logic [STOP_WIDTH-1:0]    o_stop_code,
    output logic                     o_vld,
    output logic [DATA_WIDTH-1:0]    o_data,
    input  logic                     i_vld,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic                     o_timeout,
    output logic [SIG_WIDTH-1:0]     o_signature,
    output logic [7:0]               o_fail_cnt
);

    localparam logic [1:0]               c_MODE_BIST = 2'b11;
    localparam logic [TIMEOUT_WIDTH-1:0] c_TMO_ONE   = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_mode;
    logic [2:0]               r_bypass;
    logic [STOP_WIDTH-1:0]    r_stop_code;
    logic                     r_vld;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [SIG_WIDTH-1:0]     r_golden;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_limit;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic                     r_ovf;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic                     r_timeout;
    logic [SIG_WIDTH-1:0]     r_signature;

    logic w_upper_nz;
    logic w_tmo_last;
    logic w_match;

    // Any set bit above the signature field means the wrapper output is polluted.
    generate
        if (DATA_WIDTH > SIG_WIDTH) begin : g_ovf_present
            assign w_upper_nz = |i_data[DATA_WIDTH-1:SIG_WIDTH];
        end else begin : g_ovf_absent
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_tmo_last = (r_tmo_limit != '0) && (r_tmo_cnt == (r_tmo_limit - c_TMO_ONE));
    assign w_match    = (r_signature == r_golden) && !r_ovf;

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'b00;
            r_bypass    <= 3'b000;
            r_stop_code <= '0;
            r_vld       <= 1'b0;
            r_data      <= '0;
            r_golden    <= '0;
            r_tmo_limit <= '0;
            r_tmo_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_signature <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_SEED;
                        r_golden    <= i_golden;
                        r_tmo_limit <= i_timeout;
                        r_stop_code <= i_stop_code;
                        r_tmo_cnt   <= '0;
                        r_ovf       <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_signature <= '0;
                        r_mode      <= c_MODE_BIST;
                        r_bypass    <= 3'b000;
                        r_vld       <= 1'b1;
                        r_data      <= i_seed;
                        r_busy      <= 1'b1;
                    end
                end
                S_SEED: begin
                    r_vld   <= 1'b0;
                    r_data  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    // A signature arriving on the expiry cycle still counts.
                    if (i_vld) begin
                        r_signature <= i_data[SIG_WIDTH-1:0];
                        r_ovf       <= w_upper_nz;
                        r_state     <= S_CHECK;
                    end else if (w_tmo_last) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_CHECK: begin
                    r_pass  <= w_match;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CORDIC_SIG_CHECKER_FAIL_CNT_EN
    logic [7:0] r_fail_cnt;
    logic       w_fail_event;

    assign w_fail_event = ((r_state == S_CHECK) && !w_match) ||
                          ((r_state == S_RUN) && !i_vld && w_tmo_last);

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_fail_cnt <= 8'd0;
        end else if (w_fail_event && (r_fail_cnt != 8'hFF)) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
        end
    end

    assign o_fail_cnt = r_fail_cnt;
`else
    assign o_fail_cnt = 8'd0;
`endif

    assign o_mode      = r_mode;
    assign o_bypass    = r_bypass;
    assign o_stop_code = r_stop_code;
    assign o_vld       = r_vld;
    assign o_data      = r_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_timeout   = r_timeout;
    assign o_signature = r_signature;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sig_checker.sv
// ============================================================================
// Module   : tb_cordic_sig_checker
// Purpose  : Scoreboard bench for cordic_sig_checker: driver pushes expected
//            run outcomes, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sig_checker;

    localparam int DW  = 56;
    localparam int SW  = 54;
    localparam int STW = 49;
    localparam int TW  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_start;
    logic [DW-1:0]  i_seed;
    logic [STW-1:0] i_stop_code;
    logic [SW-1:0]  i_golden;
    logic [TW-1:0]  i_timeout;
    logic           i_vld;
    logic [DW-1:0]  i_data;
    logic [1:0]     o_mode;
    logic [2:0]     o_bypass;
    logic [STW-1:0] o_stop_code;
    logic           o_vld;
    logic [DW-1:0]  o_data;
    logic           o_busy;
    logic           o_done;
    logic           o_pass;
    logic           o_timeout;
    logic [SW-1:0]  o_signature;
    logic [7:0]     o_fail_cnt;

    cordic_sig_checker #(
        .DATA_WIDTH(DW), .SIG_WIDTH(SW), .STOP_WIDTH(STW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .i_clk(clk), .i_async_rst_n(rst_n), .i_start(i_start), .i_seed(i_seed),
        .i_stop_code(i_stop_code), .i_golden(i_golden), .i_timeout(i_timeout),
        .o_mode(o_mode), .o_bypass(o_bypass), .o_stop_code(o_stop_code),
        .o_vld(o_vld), .o_data(o_data), .i_vld(i_vld), .i_data(i_data),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_signature(o_signature), .o_fail_cnt(o_fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             s;
        int             done_c;
        logic           pass;
        logic           tmo;
        logic [SW-1:0]  sig;
        logic [STW-1:0] stop;
        logic [7:0]     fcnt;
    } exp_t;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } seed_t;

    exp_t  exp_q[$];
    seed_t seed_q[$];
    bit    tb_end = 1'b0;
    int    nfail  = 0;
    int    errors = 0;
    int    checks = 0;

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [63:0] t;
        for (int i = 0; i < n; i++) begin
            i_vld  = 1'($urandom_range(0, 1));
            t      = rnd64();
            i_data = t[DW-1:0];
            step();
        end
        i_vld = 1'b0;
    endtask

    // Reference: a run ends on the signature (4 cycles after the RUN offset it
    // arrives at) unless the timeout of T RUN cycles expires first.
    task automatic do_run(input logic [DW-1:0] seed, input logic [STW-1:0] stop,
                          input logic [SW-1:0] golden, input int tmo, input int vj,
                          input logic [DW-1:0] rdata, input bit poke, input bit rst_mid);
        exp_t        e;
        seed_t       sd;
        int          s;
        bit          acc;
        logic [63:0] t;
        s   = cyc;
        acc = (vj >= 0) && (tmo == 0 || vj < tmo);
        e.s      = s;
        e.done_c = rst_mid ? 32'h4000_0000 : (acc ? s + vj + 4 : s + tmo + 2);
        e.pass   = acc && (rdata[SW-1:0] == golden) && (rdata[DW-1:SW] == '0);
        e.tmo    = !acc;
        e.sig    = acc ? rdata[SW-1:0] : '0;
        e.stop   = stop;
`ifdef CORDIC_SIG_CHECKER_FAIL_CNT_EN
        if (!e.pass && nfail < 255) nfail++;
        e.fcnt = 8'(nfail);
`else
        e.fcnt = 8'd0;
`endif
        exp_q.push_back(e);
        sd.c = s + 1;
        sd.d = seed;
        seed_q.push_back(sd);

        i_start     = 1'b1;
        i_seed      = seed;
        i_stop_code = stop;
        i_golden    = golden;
        i_timeout   = TW'(tmo);
        i_vld       = 1'b0;
        step();
        i_start     = 1'b0;
        t = rnd64(); i_seed      = t[DW-1:0];
        t = rnd64(); i_stop_code = t[STW-1:0];
        t = rnd64(); i_golden    = t[SW-1:0];
        i_timeout = TW'($urandom());
        while (cyc < e.done_c) begin
            if (rst_mid && cyc == s + 6) begin
                i_vld = 1'b0;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                nfail = 0;
                return;
            end
            i_vld   = (vj >= 0) && (cyc == s + 2 + vj);
            t       = rnd64();
            i_data  = i_vld ? rdata : t[DW-1:0];
            i_start = poke && (cyc == s + 2);
            step();
        end
        i_vld   = 1'b0;
        i_start = 1'b0;
    endtask

    // Driver
    initial begin
        logic [63:0]    t;
        logic [SW-1:0]  g;
        logic [DW-1:0]  sdv;
        logic [DW-1:0]  rd;
        logic [STW-1:0] stp;
        int             tmo;
        int             vj;
        int             k;
        rst_n = 1'b0; i_start = 1'b0; i_seed = '0; i_stop_code = '0;
        i_golden = '0; i_timeout = '0; i_vld = 1'b0; i_data = '0;
        step(); step(); step();
        rst_n = 1'b1;
        step();

        do_run(56'h1, 49'h1_2345_6789_ABCD, 54'h3_ABCD, 0, 8, 56'h3_ABCD, 1'b0, 1'b0);
        idle(2);
        do_run(56'h5, 49'h77, 54'h3_ABCD, 0, 8, 56'h3_ABCC, 1'b0, 1'b0);
        do_run(56'h9, 49'h77, 54'h0, 0, 3, 56'h80_0000_0000_0000, 1'b0, 1'b0);
        idle(3);
        do_run(56'hA, 49'h1, 54'h55, 4, -1, 56'h0, 1'b0, 1'b0);
        do_run(56'hB, 49'h2, 54'h55, 4, 3, 56'h55, 1'b0, 1'b0);
        do_run(56'hC, 49'h3, 54'h66, 0, 6, 56'h66, 1'b1, 1'b0);
        idle(3);
        do_run(56'hD, 49'h4, 54'h1, 0, -1, 56'h0, 1'b0, 1'b1);
        do_run(56'hE, 49'h5, 54'h123, 0, 2, 56'h123, 1'b0, 1'b0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            t = rnd64(); g   = t[SW-1:0];
            t = rnd64(); sdv = t[DW-1:0];
            t = rnd64(); stp = t[STW-1:0];
            tmo = int'($urandom_range(0, 12));
            vj  = (tmo != 0 && $urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 14));
            k   = int'($urandom_range(0, 2));
            t   = rnd64();
            case (k)
                0:       rd = {2'b00, g};
                1:       rd = {2'b00, g ^ (54'd1 << $urandom_range(0, 53))};
                default: rd = {t[1:0] | 2'b01, g};
            endcase
            do_run(sdv, stp, g, tmo, vj, rd, $urandom_range(0, 3) == 0, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end

        for (int n = 0; n < 260; n++) begin
            do_run(56'h3, 49'h9, 54'h7, 1, -1, 56'h0, 1'b0, 1'b0);
        end
        idle(4);
        tb_end = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t  e;
        exp_t  last;
        seed_t sd;
        bit    have_last;
        bit    exp_busy;
        have_last = 1'b0;
        while (!tb_end) begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                seed_q.delete();
                have_last = 1'b0;
                chk("rst_data", 64'(o_data), 64'd0);
                chk("rst_sig", 64'(o_signature), 64'd0);
                chk("rst_stop", 64'(o_stop_code), 64'd0);
                chk("rst_ctl", 64'({o_mode, o_bypass, o_vld, o_busy, o_done, o_pass, o_timeout, o_fail_cnt}), 64'd0);
            end else begin
                if (o_vld || (seed_q.size() > 0 && seed_q[0].c == cyc)) begin
                    if (seed_q.size() == 0) begin
                        chk("seed_unexpected_vld", 64'(o_vld), 64'd0);
                    end else begin
                        sd = seed_q.pop_front();
                        chk("seed_vld", 64'(o_vld), 64'd1);
                        chk("seed_cycle", 64'(cyc), 64'(sd.c));
                        chk("seed_data", 64'(o_data), 64'(sd.d));
                        chk("seed_mode", 64'({o_mode, o_bypass}), 64'({2'b11, 3'b000}));
                        chk("seed_clear", 64'({o_signature, o_pass, o_timeout}), 64'd0);
                    end
                end else begin
                    chk("data_idle", 64'(o_data), 64'd0);
                end

                if (o_done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 64'(o_done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", 64'(cyc - e.s), 64'(e.done_c - e.s));
                        chk("pass", 64'(o_pass), 64'(e.pass));
                        chk("timeout", 64'(o_timeout), 64'(e.tmo));
                        chk("signature", 64'(o_signature), 64'(e.sig));
                        chk("done_stop", 64'(o_stop_code), 64'(e.stop));
                        chk("done_mode", 64'({o_mode, o_bypass}), 64'({2'b11, 3'b000}));
                        chk("fail_cnt", 64'(o_fail_cnt), 64'(e.fcnt));
                        last      = e;
                        have_last = 1'b1;
                    end
                end else if (!o_busy && have_last) begin
                    chk("hold_result", 64'({o_pass, o_timeout}), 64'({last.pass, last.tmo}));
                    chk("hold_sig", 64'(o_signature), 64'(last.sig));
                    chk("hold_stop", 64'(o_stop_code), 64'(last.stop));
                    chk("hold_mode", 64'(o_mode), 64'd3);
                end

                exp_busy = (exp_q.size() > 0) && (cyc > exp_q[0].s) && (cyc < exp_q[0].done_c);
                chk("busy", 64'(o_busy), 64'(exp_busy));
            end
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
